// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle computer.
// Each instruction is sequenced through FETCH and DECODE, then through one of
// the execute, memory or branch paths, and back to FETCH. Control values are
// Moore outputs of the current state. The architectural write enables are also
// gated by COND_EX, and all of them are forced low while RESET_N is asserted.

module multicycle_main_fsm (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] INSTRUCTION,
    input  logic        COND_EX,
    output logic        PC_WRITE,
    output logic        IR_WRITE,
    output logic        REG_WRITE,
    output logic        MEM_WRITE,
    output logic        FLAG_WRITE,
    output logic        ADR_SRC,
    output logic        ALU_SRC_A,
    output logic [1:0]  ALU_SRC_B,
    output logic        ALU_OP,
    output logic [1:0]  RESULT_SRC,
    output logic [3:0]  STATE
);

    // State encodings are fixed because they are visible on the STATE debug port.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // Operand-B and result-bus select codes.
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Instruction-type encodings of the op field.
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    state_t state_q;
    state_t state_d;

    // Instruction fields, same layout as the instruction decoder.
    logic [1:0] op;
    logic       imm_bit;
    logic [3:0] cmd;
    logic       s_or_l;
    logic       no_write;

    assign op       = INSTRUCTION[27:26];
    assign imm_bit  = INSTRUCTION[25];
    assign cmd      = INSTRUCTION[24:21];
    assign s_or_l   = INSTRUCTION[20];

    // TST/TEQ/CMP/CMN only update flags, never the register file.
    assign no_write = (op == OP_DP) && (cmd[3:2] == 2'b10);

    // Condition field and operand fields are consumed elsewhere in the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{INSTRUCTION[31:28], INSTRUCTION[19:0]};

    // Ungated per-state write requests.
    logic next_pc;
    logic ir_w;
    logic regw;
    logic memw;
    logic flagw;
    logic branch;

    // State register; reset puts the machine in FETCH immediately.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and Moore control values for the current state.
    always_comb begin
        state_d    = S_FETCH;
        next_pc    = 1'b0;
        ir_w       = 1'b0;
        regw       = 1'b0;
        memw       = 1'b0;
        flagw      = 1'b0;
        branch     = 1'b0;
        ADR_SRC    = 1'b0;
        ALU_SRC_A  = 1'b0;
        ALU_SRC_B  = SRCB_REG;
        ALU_OP     = 1'b0;
        RESULT_SRC = RES_ALUOUT;

        case (state_q)
            S_FETCH: begin
                // Read instruction at PC and compute PC+4 on the live ALU output.
                state_d    = S_DECODE;
                ir_w       = 1'b1;
                next_pc    = 1'b1;
                ADR_SRC    = 1'b0;
                ALU_SRC_A  = 1'b1;
                ALU_SRC_B  = SRCB_FOUR;
                ALU_OP     = 1'b0;
                RESULT_SRC = RES_ALU;
            end
            S_DECODE: begin
                // Registers are read; the ALU forms PC+8 for use as R15.
                ALU_SRC_A  = 1'b1;
                ALU_SRC_B  = SRCB_FOUR;
                ALU_OP     = 1'b0;
                RESULT_SRC = RES_ALU;
                case (op)
                    OP_DP:   state_d = imm_bit ? S_EXECI : S_EXECR;
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                // Base register plus immediate offset gives the address.
                state_d   = s_or_l ? S_MEMRD : S_MEMWR;
                ALU_SRC_B = SRCB_IMM;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
                ADR_SRC = 1'b1;
            end
            S_MEMWB: begin
                state_d    = S_FETCH;
                RESULT_SRC = RES_MEM;
                regw       = 1'b1;
            end
            S_MEMWR: begin
                state_d = S_FETCH;
                ADR_SRC = 1'b1;
                memw    = 1'b1;
            end
            S_EXECR: begin
                state_d   = S_ALUWB;
                ALU_SRC_B = SRCB_REG;
                ALU_OP    = 1'b1;
                flagw     = s_or_l;
            end
            S_EXECI: begin
                state_d   = S_ALUWB;
                ALU_SRC_B = SRCB_IMM;
                ALU_OP    = 1'b1;
                flagw     = s_or_l;
            end
            S_ALUWB: begin
                state_d = S_FETCH;
                regw    = ~no_write;
            end
            S_BRANCH: begin
                // Target = PC+8 + offset, loaded straight from the live ALU.
                state_d    = S_FETCH;
                ALU_SRC_B  = SRCB_IMM;
                RESULT_SRC = RES_ALU;
                branch     = 1'b1;
            end
            default: begin
                // Illegal encodings recover to FETCH with nothing written.
                state_d = S_FETCH;
            end
        endcase
    end

    // Write enables: condition-gated where architectural, and held low in reset.
    assign IR_WRITE   = ir_w & RESET_N;
    assign PC_WRITE   = (next_pc | (branch & COND_EX)) & RESET_N;
    assign REG_WRITE  = regw  & COND_EX & RESET_N;
    assign MEM_WRITE  = memw  & COND_EX & RESET_N;
    assign FLAG_WRITE = flagw & COND_EX & RESET_N;

    assign STATE = state_q;

endmodule
